// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC sequencer: one combinational rotation stage reused for ITERS cycles.
// Optional macro CORDIC_SIGNED_THETA_EN accepts signed angles over [-pi/2, pi/2].

module cordic_engine (
   input  logic [4:0]  i,
   input  logic [31:0] a_i,
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic [31:0] w,
   input  logic [31:0] theta,
   output logic [31:0] x_n,
   output logic [31:0] y_n,
   output logic [31:0] w_n
);
   logic signed [31:0] x_sh_s;
   logic signed [31:0] y_sh_s;

   // One micro-rotation; rotate toward theta based on accumulated angle w.
   always_comb begin
      x_sh_s = $signed(x) >>> i;
      y_sh_s = $signed(y) >>> i;
      if ($signed(w) <= $signed(theta)) begin
         x_n = x - y_sh_s;
         y_n = y + x_sh_s;
         w_n = w + a_i;
      end else begin
         x_n = x + y_sh_s;
         y_n = y - x_sh_s;
         w_n = w - a_i;
      end
   end
endmodule

module cordic_iter_ctrl #(
   parameter int          ITERS  = 16,
   parameter logic [31:0] X_INIT = 32'h26DD3B6A
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] theta,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] cos_o,
   output logic [31:0] sin_o,
   output logic        busy
);
   localparam logic [31:0] HALF_PI  = 32'h6487ED51;
   localparam logic [4:0]  LAST_CNT = 5'(ITERS - 1);

   generate
      if (ITERS < 4 || ITERS > 31) begin : g_bad_iters
         $error("cordic_iter_ctrl: ITERS must be within 4..31");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // round(atan(2^-k) * 2^30); from k=10 on the value rounds to 2^(30-k)
   function automatic logic [31:0] atan_rom(input logic [4:0] k);
      case (k)
         5'd0:    atan_rom = 32'h3243F6A9;
         5'd1:    atan_rom = 32'h1DAC6705;
         5'd2:    atan_rom = 32'h0FADBAFD;
         5'd3:    atan_rom = 32'h07F56EA7;
         5'd4:    atan_rom = 32'h03FEAB77;
         5'd5:    atan_rom = 32'h01FFD55C;
         5'd6:    atan_rom = 32'h00FFFAAB;
         5'd7:    atan_rom = 32'h007FFF55;
         5'd8:    atan_rom = 32'h003FFFEB;
         5'd9:    atan_rom = 32'h001FFFFD;
         5'd10:   atan_rom = 32'h00100000;
         5'd11:   atan_rom = 32'h00080000;
         5'd12:   atan_rom = 32'h00040000;
         5'd13:   atan_rom = 32'h00020000;
         5'd14:   atan_rom = 32'h00010000;
         5'd15:   atan_rom = 32'h00008000;
         5'd16:   atan_rom = 32'h00004000;
         5'd17:   atan_rom = 32'h00002000;
         5'd18:   atan_rom = 32'h00001000;
         5'd19:   atan_rom = 32'h00000800;
         5'd20:   atan_rom = 32'h00000400;
         5'd21:   atan_rom = 32'h00000200;
         5'd22:   atan_rom = 32'h00000100;
         5'd23:   atan_rom = 32'h00000080;
         5'd24:   atan_rom = 32'h00000040;
         5'd25:   atan_rom = 32'h00000020;
         5'd26:   atan_rom = 32'h00000010;
         5'd27:   atan_rom = 32'h00000008;
         5'd28:   atan_rom = 32'h00000004;
         5'd29:   atan_rom = 32'h00000002;
         5'd30:   atan_rom = 32'h00000001;
         default: atan_rom = 32'h00000000;
      endcase
   endfunction

   function automatic logic [31:0] clamp_angle(input logic [31:0] a);
      if (a > HALF_PI) begin
         clamp_angle = HALF_PI;
      end else begin
         clamp_angle = a;
      end
   endfunction

   state_t      state_r, state_s;
   logic [31:0] x_r, y_r, w_r, theta_r;
   logic [31:0] x_s, y_s, w_s, theta_s;
   logic [4:0]  cnt_r, cnt_s;
   logic [31:0] cos_r, sin_r, cos_s, sin_s;
   logic        out_valid_r, out_valid_s;
   logic        in_ready_r, in_ready_s;
   logic        busy_r, busy_s;
   logic [31:0] eng_x_s, eng_y_s, eng_w_s;
`ifdef CORDIC_SIGNED_THETA_EN
   logic        neg_r, neg_s;
   logic [31:0] mag_s;
`endif

   cordic_engine u_engine (
      .i     (cnt_r),
      .a_i   (atan_rom(cnt_r)),
      .x     (x_r),
      .y     (y_r),
      .w     (w_r),
      .theta (theta_r),
      .x_n   (eng_x_s),
      .y_n   (eng_y_s),
      .w_n   (eng_w_s)
   );

   // Next-state and next-register values for the sequencer.
   always_comb begin
      state_s     = state_r;
      x_s         = x_r;
      y_s         = y_r;
      w_s         = w_r;
      theta_s     = theta_r;
      cnt_s       = cnt_r;
      cos_s       = cos_r;
      sin_s       = sin_r;
      out_valid_s = out_valid_r;
      in_ready_s  = 1'b0;
      busy_s      = 1'b0;
`ifdef CORDIC_SIGNED_THETA_EN
      neg_s = neg_r;
      if (theta[31]) begin
         mag_s = 32'd0 - theta;
      end else begin
         mag_s = theta;
      end
`endif
      case (state_r)
         ST_IDLE: begin
            if (in_valid && in_ready_r) begin
`ifdef CORDIC_SIGNED_THETA_EN
               theta_s = clamp_angle(mag_s);
               neg_s   = theta[31];
`else
               theta_s = clamp_angle(theta);
`endif
               x_s     = X_INIT;
               y_s     = 32'd0;
               w_s     = 32'd0;
               cnt_s   = 5'd0;
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            x_s   = eng_x_s;
            y_s   = eng_y_s;
            w_s   = eng_w_s;
            cnt_s = cnt_r + 5'd1;
            if (cnt_r == LAST_CNT) begin
               cos_s = eng_x_s;
`ifdef CORDIC_SIGNED_THETA_EN
               if (neg_r) begin
                  sin_s = 32'd0 - eng_y_s;
               end else begin
                  sin_s = eng_y_s;
               end
`else
               sin_s = eng_y_s;
`endif
               out_valid_s = 1'b1;
               state_s     = ST_DONE;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_s = 1'b0;
               state_s     = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            out_valid_s = 1'b0;
            state_s     = ST_IDLE;
         end
      endcase
      if (state_s == ST_IDLE) begin
         in_ready_s = 1'b1;
         busy_s     = 1'b0;
      end else begin
         in_ready_s = 1'b0;
         busy_s     = 1'b1;
      end
   end

   // State and datapath registers; a reset discards any in-flight rotation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         x_r         <= 32'd0;
         y_r         <= 32'd0;
         w_r         <= 32'd0;
         theta_r     <= 32'd0;
         cnt_r       <= 5'd0;
         cos_r       <= 32'd0;
         sin_r       <= 32'd0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
`ifdef CORDIC_SIGNED_THETA_EN
         neg_r       <= 1'b0;
`endif
      end else begin
         state_r     <= state_s;
         x_r         <= x_s;
         y_r         <= y_s;
         w_r         <= w_s;
         theta_r     <= theta_s;
         cnt_r       <= cnt_s;
         cos_r       <= cos_s;
         sin_r       <= sin_s;
         out_valid_r <= out_valid_s;
         in_ready_r  <= in_ready_s;
         busy_r      <= busy_s;
`ifdef CORDIC_SIGNED_THETA_EN
         neg_r       <= neg_s;
`endif
      end
   end

   assign in_ready  = in_ready_r;
   assign busy      = busy_r;
   assign out_valid = out_valid_r;
   assign cos_o     = cos_r;
   assign sin_o     = sin_r;
endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed self-checking bench for cordic_iter_ctrl (ITERS=16, default X_INIT).
// Define CORDIC_SIGNED_THETA_EN for both files to exercise the signed-angle test.

module tb_cordic_iter_ctrl;
   localparam int          TOL     = 65536;
   localparam int          LAT     = 17;
   localparam logic [31:0] ONE     = 32'h40000000;
   localparam logic [31:0] PI_4    = 32'h3243F6A9;
   localparam logic [31:0] C_PI_4  = 32'h2D413CCD;
   localparam logic [31:0] C_HALF  = 32'd942297101;
   localparam logic [31:0] S_HALF  = 32'd514779254;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] theta;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] cos_o;
   logic [31:0] sin_o;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;

   cordic_iter_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .theta     (theta),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .cos_o     (cos_o),
      .sin_o     (sin_o),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic int unsigned adiff(input logic [31:0] a, input logic [31:0] b);
      logic signed [32:0] d;
      d = $signed({a[31], a}) - $signed({b[31], b});
      if (d < 0) d = -d;
      return d[31:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request with out_ready high; returns edge count to out_valid (0 = timeout).
   task automatic do_req(input logic [31:0] th, output logic [31:0] c,
                         output logic [31:0] s, output int lat);
      in_valid  = 1'b1;
      theta     = th;
      out_ready = 1'b1;
      lat = 0;
      c   = 32'd0;
      s   = 32'd0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         in_valid = 1'b0;
         if (out_valid) begin
            lat = n;
            c   = cos_o;
            s   = sin_o;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [65:0] got;
      rst_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid  = 1'($urandom);
         theta     = $urandom;
         out_ready = 1'($urandom);
         tick();
         got = {in_ready, out_valid, busy, 31'd0, cos_o, sin_o} >> 31;
         vectors++;
         if ({in_ready, out_valid, busy, cos_o, sin_o} !== {1'b1, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b cos=%h sin=%h, want 1 0 0 0 0",
                     in_ready, out_valid, busy, cos_o, sin_o);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      theta     = 32'd0;
      rst_n     = 1'b1;
      tick();
   endtask

   task automatic test_zero();
      logic [31:0] c, s;
      int lat;
      do_req(32'd0, c, s, lat);
      vectors++;
      if (lat !== LAT) begin
         miscompares++;
         $display("FAIL zero_latency: got %0d edges, want %0d", lat, LAT);
      end
      vectors++;
      if (adiff(c, ONE) > TOL || adiff(s, 32'd0) > TOL) begin
         miscompares++;
         $display("FAIL zero_value: got cos=%h sin=%h, want ~%h ~0", c, s, ONE);
      end
      tick();
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_return_idle: got rdy=%b busy=%b vld=%b, want 1 0 0",
                  in_ready, busy, out_valid);
      end
   endtask

   task automatic test_pi4();
      logic [31:0] c, s;
      int lat;
      do_req(PI_4, c, s, lat);
      tick();
      vectors++;
      if (lat !== LAT || adiff(c, C_PI_4) > TOL || adiff(s, C_PI_4) > TOL) begin
         miscompares++;
         $display("FAIL pi4_value: got lat=%0d cos=%h sin=%h, want %0d ~%h ~%h",
                  lat, c, s, LAT, C_PI_4, C_PI_4);
      end
   endtask

   task automatic test_clamp();
      logic [31:0] c, s;
      int lat;
      do_req(32'h7FFFFFFF, c, s, lat);
      tick();
      vectors++;
      if (lat !== LAT || adiff(c, 32'd0) > TOL || adiff(s, ONE) > TOL) begin
         miscompares++;
         $display("FAIL clamp_value: got lat=%0d cos=%h sin=%h, want %0d ~0 ~%h",
                  lat, c, s, LAT, ONE);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] c, s;
      int lat;
      bit  bad;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      theta     = 32'h20000000;
      lat = 0;
      bad = 1'b0;
      c   = 32'd0;
      s   = 32'd0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         theta    = 32'h7FFFFFFF;
         in_valid = n[0];
         if (out_valid) begin
            lat = n;
            c   = cos_o;
            s   = sin_o;
            break;
         end
         if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      end
      vectors++;
      if (lat !== LAT || bad) begin
         miscompares++;
         $display("FAIL bp_run: got lat=%0d ready_during_run_err=%b, want %0d 0", lat, bad, LAT);
      end
      bad = 1'b0;
      for (int k = 0; k < 10; k++) begin
         in_valid = ~in_valid;
         tick();
         if (out_valid !== 1'b1 || cos_o !== c || sin_o !== s || in_ready !== 1'b0 || busy !== 1'b1)
            bad = 1'b1;
      end
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL bp_hold: got outputs changed during stall (bad=%b), want stable", bad);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_ready_same_cycle: got in_ready=%b, want 0", in_ready);
      end
      tick();
      in_valid = 1'b0;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || cos_o !== c || sin_o !== s) begin
         miscompares++;
         $display("FAIL bp_release: got rdy=%b vld=%b cos=%h sin=%h, want 1 0 %h %h",
                  in_ready, out_valid, cos_o, sin_o, c, s);
      end
      vectors++;
      if (adiff(c, C_HALF) > TOL || adiff(s, S_HALF) > TOL) begin
         miscompares++;
         $display("FAIL bp_value: got cos=%h sin=%h, want ~%h ~%h", c, s, C_HALF, S_HALF);
      end
      tick();
      vectors++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_not_queued: got busy=%b rdy=%b, want 0 1", busy, in_ready);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] c, s;
      int lat;
      bit  seen;
      in_valid  = 1'b1;
      theta     = PI_4;
      out_ready = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         tick();
         in_valid = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({in_ready, busy, out_valid, cos_o, sin_o} !== {1'b1, 1'b0, 1'b0, 32'd0, 32'd0}) begin
         miscompares++;
         $display("FAIL midrun_reset: got rdy=%b busy=%b vld=%b cos=%h sin=%h, want 1 0 0 0 0",
                  in_ready, busy, out_valid, cos_o, sin_o);
      end
      tick();
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      vectors++;
      if (seen) begin
         miscompares++;
         $display("FAIL midrun_no_valid: got out_valid asserted=%b, want 0", seen);
      end
      do_req(32'd0, c, s, lat);
      tick();
      vectors++;
      if (lat !== LAT || adiff(c, ONE) > TOL || adiff(s, 32'd0) > TOL) begin
         miscompares++;
         $display("FAIL midrun_fresh: got lat=%0d cos=%h sin=%h, want %0d ~%h ~0",
                  lat, c, s, LAT, ONE);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] c1, s1, c2, s2;
      int first, second;
      first = 0; second = 0;
      c1 = 32'd0; s1 = 32'd0; c2 = 32'd0; s2 = 32'd0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      theta     = 32'd0;
      for (int n = 1; n <= 60; n++) begin
         tick();
         theta = PI_4;
         if (n >= 19) in_valid = 1'b0;
         if (out_valid && first == 0) begin
            first = n; c1 = cos_o; s1 = sin_o;
         end else if (out_valid && second == 0) begin
            second = n; c2 = cos_o; s2 = sin_o;
            break;
         end
      end
      in_valid = 1'b0;
      vectors++;
      if (first !== LAT || second !== 2 * LAT + 1) begin
         miscompares++;
         $display("FAIL b2b_timing: got %0d and %0d, want %0d and %0d", first, second, LAT, 2 * LAT + 1);
      end
      vectors++;
      if (adiff(c1, ONE) > TOL || adiff(s1, 32'd0) > TOL ||
          adiff(c2, C_PI_4) > TOL || adiff(s2, C_PI_4) > TOL) begin
         miscompares++;
         $display("FAIL b2b_values: got %h %h / %h %h, want ~%h ~0 / ~%h ~%h",
                  c1, s1, c2, s2, ONE, C_PI_4, C_PI_4);
      end
      for (int k = 0; k < 40 && !in_ready; k++) tick();
      tick();
   endtask

`ifdef CORDIC_SIGNED_THETA_EN
   task automatic test_signed();
      logic [31:0] c, s, exp_s;
      int lat;
      exp_s = 32'd0 - C_PI_4;
      do_req(32'd0 - PI_4, c, s, lat);
      tick();
      vectors++;
      if (lat !== LAT || adiff(c, C_PI_4) > TOL || adiff(s, exp_s) > TOL) begin
         miscompares++;
         $display("FAIL signed_neg_pi4: got lat=%0d cos=%h sin=%h, want %0d ~%h ~%h",
                  lat, c, s, LAT, C_PI_4, exp_s);
      end
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      theta     = 32'd0;
      test_reset();
      test_zero();
      test_pi4();
      test_clamp();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
`ifdef CORDIC_SIGNED_THETA_EN
      test_signed();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/cordic_iter_ctrl.md
Name: cordic_iter_ctrl

Overview:
Iterative sequencer for the single-stage combinational CORDIC rotation engine. It accepts an angle, then reuses one `engine` instance for ITERS clock cycles. Each cycle it feeds back the registered x/y/w state, presents the iteration index i, and supplies the arctangent constant for that i from an internal ROM. The final cos/sin pair is returned over a valid/ready handshake. It sits between the angle source (NCO / command register) and the downstream consumer of sin/cos.

Parameters:
- ITERS, 16, number of micro-rotations; legal range 4..31.
- X_INIT, 32'h26DD3B6A, initial x (CORDIC gain K = 0.6072529 in Q2.30); y and w start at 0.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  angle request
- in_ready  output  1  high only in IDLE; request is accepted when in_valid & in_ready
- theta  input  32  target angle, unsigned Q2.30 rad (1.0 = 32'h40000000); sampled on accept
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- cos_o  output  32  signed Q2.30 cosine, stable while out_valid
- sin_o  output  32  signed Q2.30 sine, stable while out_valid
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync release): state=IDLE; x_r, y_r, w_r, theta_r, cnt, cos_o, sin_o, out_valid, busy all 0; in_ready=1.
- States:
  - IDLE: in_ready=1. On accept: theta_r <= min(theta, 32'h6487ED51), i.e. clamp to pi/2. Also x_r<=X_INIT, y_r<=0, w_r<=0, cnt<=0, then go to RUN.
  - RUN: the engine is driven with i=cnt, a_i=ATAN[cnt], x_r/y_r/w_r, theta_r. Each cycle, engine outputs are registered into x_r/y_r/w_r and cnt increments. When cnt==ITERS-1, that cycle's engine outputs are captured into cos_o/sin_o, out_valid<=1, and the state goes to DONE.
  - DONE: out_valid=1, outputs held. On out_ready, out_valid<=0 and the state goes to IDLE. cos_o/sin_o keep their last value.
- Latency: an accept in cycle 0 gives out_valid high from cycle ITERS+1. If out_ready is held high, the next in_ready is at cycle ITERS+2. Throughput is 1 result per ITERS+2 cycles.
- ATAN ROM: entry k = round(atan(2^-k)·2^30). Entry 0 = 32'h3243F6A9. Entries cover 0..30; entries at or beyond ITERS are unused.
- Arithmetic: all 32-bit. Shifts are arithmetic, per the engine. Wrap-around is not possible for clamped theta. No rounding is added beyond the engine's.
- in_valid while busy: ignored, not queued; theta is not resampled.
- out_ready while not out_valid: no effect.
- Reset mid-RUN or mid-DONE: returns to IDLE immediately; the partial result is discarded and out_valid drops asynchronously.
- ITERS outside 4..31: elaboration error ($error).

Optional Feature:
- Macro: CORDIC_SIGNED_THETA_EN.
- With the macro: theta is signed two's-complement Q2.30. On accept, theta_r <= min(|theta|, pi/2) and a neg flag is registered. In DONE, sin_o = -result and cos_o = result unchanged. This covers [-pi/2, pi/2]. theta = 32'h80000000 is treated as -pi/2.
- Without the macro: theta is unsigned, no neg flag, values above pi/2 are clamped. This is identical to the Behaviour section.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> in_ready=1, out_valid=0, cos_o=sin_o=0, busy=0.
- theta=0, ITERS=16 -> out_valid exactly at cycle 17; cos_o≈32'h40000000, sin_o≈0, each within ±2^16 LSB.
- theta=32'h3243F6A9 (pi/4) -> cos_o≈sin_o≈32'h2D413CCD within ±2^16. theta=32'h7FFFFFFF (clamp) -> cos_o≈0, sin_o≈32'h40000000.
- Backpressure: out_ready=0 for 10 cycles after out_valid, with in_valid pulsed during RUN and DONE -> outputs stable, extra requests dropped, in_ready=0 until the cycle after out_ready.
- Reset asserted at RUN cnt=7 -> immediate IDLE, out_valid never asserts. A fresh theta=0 request afterwards gives a correct result at the normal latency.
- With CORDIC_SIGNED_THETA_EN, theta=-32'h3243F6A9 -> cos_o≈32'h2D413CCD, sin_o≈-32'h2D413CCD within ±2^16.
